// File: rtl/ternary_pkg.sv
// Shared types and constants for the ternary (1.58-bit) matmul datapath:
// sequencer state encoding, array geometry and 2-bit weight codes.
package ternary_pkg;

  localparam int ARRAY_ROWS = 4;
  localparam int ARRAY_PIPE = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    FLUSH,
    CAPTURE,
    EMIT
  } seq_state_e;

  // 11 is a second encoding of -1 so every code has a defined meaning
  typedef enum logic [1:0] {
    TERN_ZERO    = 2'b00,
    TERN_POS     = 2'b01,
    TERN_NEG     = 2'b10,
    TERN_NEG_ALT = 2'b11
  } tern_code_e;

  function automatic logic tern_is_zero(input tern_code_e code);
    return code == TERN_ZERO;
  endfunction

  function automatic logic tern_is_neg(input tern_code_e code);
    return (code == TERN_NEG) || (code == TERN_NEG_ALT);
  endfunction

endpackage

// File: rtl/ternary_weight_decode.sv
// Combinational unpack of four 2-bit ternary weights into per-lane zero/sign
// flags; lane 0 takes the most significant pair.
module ternary_weight_decode
  import ternary_pkg::*;
(
  input  logic [7:0] weights,
  output logic [3:0] zero,
  output logic [3:0] sign
);

  always_comb begin
    zero = '0;
    sign = '0;
    for (int i = 0; i < 4; i++) begin
      zero[i] = tern_is_zero(tern_code_e'(weights[7-2*i -: 2]));
      sign[i] = tern_is_neg(tern_code_e'(weights[7-2*i -: 2]));
    end
  end

endmodule

// File: rtl/ternary_matmul_sequencer.sv
// Job controller for the 4-row ternary systolic array: streams K beats in,
// drains the array pipeline, captures the result bytes and emits them.
module ternary_matmul_sequencer
  import ternary_pkg::*;
#(
  parameter int K_W      = 12,
  parameter int ROWS     = ARRAY_ROWS,
  parameter int ARR_PIPE = ARRAY_PIPE
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [K_W-1:0] cmd_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_weights,
  input  logic [7:0]     in_act,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_data,
  output logic           out_last,
  output logic           busy,
  output logic [3:0]     arr_left_zero,
  output logic [3:0]     arr_left_sign,
  output logic [7:0]     arr_top,
  output logic           arr_restart_inputs,
  output logic           arr_reset_accumulators,
  output logic           arr_copy_to_out_queue,
  output logic           arr_restart_out_queue,
  input  logic [7:0]     arr_out
);

  // One counter serves the drain, capture and emit phases in turn
  localparam int CNT_W = $clog2((ROWS > ARR_PIPE) ? ROWS : ARR_PIPE);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ARR_PIPE - 1);
  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROWS - 1);

  seq_state_e     state_q, state_d;
  logic [K_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]     res_buf_q [ROWS];
  logic [7:0]     res_buf_d [ROWS];

  logic       beat;
  logic [3:0] dec_zero;
  logic [3:0] dec_sign;

  ternary_weight_decode u_decode (
    .weights (in_weights),
    .zero    (dec_zero),
    .sign    (dec_sign)
  );

  assign beat = in_valid && (state_q == FEED);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    res_buf_d   = res_buf_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          remaining_d = cmd_len;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = (remaining_q != '0) ? FEED : DRAIN;
      end
      FEED: begin
        if (beat) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == K_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        cnt_d   = '0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // The array's out queue advances one row per cycle after FLUSH
        res_buf_d[cnt_q] = arr_out;
        if (cnt_q == ROW_LAST) begin
          cnt_d   = '0;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (cnt_q == ROW_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      cnt_q       <= '0;
      for (int r = 0; r < ROWS; r++) res_buf_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      for (int r = 0; r < ROWS; r++) res_buf_q[r] <= res_buf_d[r];
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign in_ready  = (state_q == FEED);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_valid ? res_buf_q[cnt_q] : 8'h00;
  assign out_last  = out_valid && (cnt_q == ROW_LAST);

  assign arr_restart_inputs     = (state_q == CLEAR);
  assign arr_reset_accumulators = (state_q == CLEAR) || (state_q == FLUSH);
  assign arr_copy_to_out_queue  = (state_q == FLUSH);
  assign arr_restart_out_queue  = (state_q == FLUSH);

  // Anything but an accepted beat presents all-zero weights to the array
  assign arr_left_zero = beat ? dec_zero : 4'hF;
  assign arr_left_sign = beat ? dec_sign : 4'h0;
  assign arr_top       = beat ? in_act   : 8'h00;

endmodule

// File: tb/tb_ternary_matmul_sequencer.sv
// Bench for ternary_matmul_sequencer with a behavioural stand-in for the
// systolic array and a plain-arithmetic dot-product reference.
module tb_ternary_matmul_sequencer;

  localparam int K_W  = 12;
  localparam int ROWS = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [K_W-1:0] cmd_len;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     in_weights;
  logic [7:0]     in_act;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     out_data;
  logic           out_last;
  logic           busy;
  logic [3:0]     arr_left_zero;
  logic [3:0]     arr_left_sign;
  logic [7:0]     arr_top;
  logic           arr_restart_inputs;
  logic           arr_reset_accumulators;
  logic           arr_copy_to_out_queue;
  logic           arr_restart_out_queue;
  logic [7:0]     arr_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fed    = 0;

  logic [7:0] wq[$];
  logic [7:0] aq[$];
  logic [7:0] exp_b [ROWS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ternary_matmul_sequencer #(.K_W(K_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_len                (cmd_len),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_weights             (in_weights),
    .in_act                 (in_act),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out_data               (out_data),
    .out_last               (out_last),
    .busy                   (busy),
    .arr_left_zero          (arr_left_zero),
    .arr_left_sign          (arr_left_sign),
    .arr_top                (arr_top),
    .arr_restart_inputs     (arr_restart_inputs),
    .arr_reset_accumulators (arr_reset_accumulators),
    .arr_copy_to_out_queue  (arr_copy_to_out_queue),
    .arr_restart_out_queue  (arr_restart_out_queue),
    .arr_out                (arr_out)
  );

  // Systolic array stand-in: 2-cycle argument pipe, 17-bit accumulators,
  // out queue copied from accumulators_next and read one row per cycle.
  logic [3:0]         p1_z, p2_z, p1_s, p2_s;
  logic [7:0]         p1_t, p2_t;
  logic signed [16:0] acc [ROWS];
  logic signed [16:0] acc_nx [ROWS];
  logic signed [16:0] oq [ROWS];
  logic [1:0]         qcnt;

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      acc_nx[r] = acc[r];
      if (!p2_z[r])
        acc_nx[r] = p2_s[r] ? acc[r] - {{9{p2_t[7]}}, p2_t}
                            : acc[r] + {{9{p2_t[7]}}, p2_t};
    end
  end

  always @(posedge clk) begin
    if (reset || arr_restart_inputs) begin
      p1_z <= 4'hF; p1_s <= 4'h0; p1_t <= 8'h00;
      p2_z <= 4'hF; p2_s <= 4'h0; p2_t <= 8'h00;
    end else begin
      p1_z <= arr_left_zero; p1_s <= arr_left_sign; p1_t <= arr_top;
      p2_z <= p1_z; p2_s <= p1_s; p2_t <= p1_t;
    end
    for (int r = 0; r < ROWS; r++) begin
      if (reset) begin
        acc[r] <= '0;
        oq[r]  <= '0;
      end else begin
        acc[r] <= arr_reset_accumulators ? 17'sd0 : acc_nx[r];
        if (arr_copy_to_out_queue) oq[r] <= acc_nx[r];
      end
    end
    qcnt <= (reset || arr_restart_out_queue) ? 2'd0 : qcnt + 2'd1;
  end

  assign arr_out = oq[qcnt][15:8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: each row is sum(ternary(w)*act) over all beats, byte = bits[15:8]
  function automatic void compute_expected();
    int s;
    int t;
    logic [1:0]  pr;
    logic [31:0] sv;
    for (int r = 0; r < ROWS; r++) begin
      s = 0;
      for (int b = 0; b < wq.size(); b++) begin
        pr = wq[b][7-2*r -: 2];
        t  = (pr == 2'b00) ? 0 : (pr[1] ? -1 : 1);
        s += t * int'($signed(aq[b]));
      end
      sv = s;
      exp_b[r] = sv[15:8];
    end
  endfunction

  function automatic logic [3:0] exp_zero(input logic [7:0] w);
    logic [3:0] z;
    for (int i = 0; i < 4; i++) z[i] = (w[7-2*i -: 2] == 2'b00);
    return z;
  endfunction

  function automatic logic [3:0] exp_sign(input logic [7:0] w);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = w[7-2*i];
    return s;
  endfunction

  task automatic load_const(input int k, input logic [7:0] w, input logic [7:0] a);
    wq.delete(); aq.delete();
    for (int i = 0; i < k; i++) begin wq.push_back(w); aq.push_back(a); end
  endtask

  task automatic load_rand(input int k);
    wq.delete(); aq.delete();
    for (int i = 0; i < k; i++) begin
      wq.push_back(8'($urandom));
      aq.push_back(8'($urandom));
    end
  endtask

  // All tasks below start and end at a falling clock edge.
  task automatic send_cmd(input int k, output int c0);
    bit done;
    done = 0;
    c0 = 0;
    cmd_valid = 1'b1;
    cmd_len = k[K_W-1:0];
    for (int g = 0; g < 40 && !done; g++) begin
      #1;
      if (cmd_ready) begin
        @(posedge clk); #1;
        c0 = cyc;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    cmd_len = '0;
    if (!done) check_eq("cmd_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic feed(input int stall_mode, input int upto);
    int guard;
    bit bubble;
    guard = 0;
    while (fed < upto && guard < 400) begin
      bubble = (stall_mode == 1 && cyc % 2 == 0) ||
               (stall_mode == 2 && $urandom_range(0, 2) == 0);
      if (bubble) begin
        in_valid = 1'b0;
        in_weights = 8'($urandom);
        in_act = 8'($urandom);
        #1;
        if (in_ready) begin
          check_eq("bubble_zero", 32'(arr_left_zero), 32'hF);
          check_eq("bubble_top", 32'(arr_top), 32'h0);
        end
      end else begin
        in_valid = 1'b1;
        in_weights = wq[fed];
        in_act = aq[fed];
        #1;
        if (in_ready) begin
          check_eq("lane_zero", 32'(arr_left_zero), 32'(exp_zero(wq[fed])));
          check_eq("lane_sign", 32'(arr_left_sign), 32'(exp_sign(wq[fed])));
          check_eq("lane_top", 32'(arr_top), 32'(aq[fed]));
          fed++;
        end
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (fed < upto) check_eq("feed_timeout", 32'(fed), 32'(upto));
  endtask

  task automatic collect(input int c0, input bit lat_chk, input int k,
                         input int bp_idx, input int bp_len);
    int idx, hold, guard;
    bit seen;
    idx = 0; hold = 0; guard = 0; seen = 0;
    while (idx < ROWS && guard < 600) begin
      if (bp_idx == -2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = !(idx == bp_idx && hold < bp_len);
      in_valid = 1'b1;
      in_weights = 8'($urandom);
      in_act = 8'($urandom);
      #1;
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          if (lat_chk) check_eq("latency", 32'(cyc - c0), 32'(k + 8));
        end
        check_eq("out_data", 32'(out_data), 32'(exp_b[idx]));
        check_eq("out_last", 32'(out_last), 32'(idx == ROWS - 1));
        check_eq("in_ready_emit", 32'(in_ready), 32'd0);
        if (!out_ready) begin
          hold++;
          check_eq("cmd_ready_bp", 32'(cmd_ready), 32'd0);
        end else begin
          idx++;
        end
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    if (idx < ROWS) check_eq("out_timeout", 32'(idx), 32'(ROWS));
    #1;
    check_eq("cmd_ready_after", 32'(cmd_ready), 32'd1);
    check_eq("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic run_job(input int stall_mode, input int bp_idx, input int bp_len);
    int c0;
    int k;
    k = wq.size();
    compute_expected();
    send_cmd(k, c0);
    fed = 0;
    feed(stall_mode, k);
    collect(c0, stall_mode == 0, k, bp_idx, bp_len);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0;
    in_weights = 8'h00; in_act = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_lane_zero", 32'(arr_left_zero), 32'hF);
    check_eq("rst_strobes", 32'({arr_restart_inputs, arr_reset_accumulators,
                                 arr_copy_to_out_queue, arr_restart_out_queue}), 32'd0);
    @(negedge clk);

    load_const(8, 8'h55, 8'h40); run_job(0, -1, 0);
    load_const(8, 8'h1B, 8'h40); run_job(0, -1, 0);
    load_const(8, 8'h55, 8'h40); run_job(1, -1, 0);
    load_const(0, 8'h00, 8'h00); run_job(0, -1, 0);
    load_const(4, 8'h55, 8'h7F); run_job(0, -1, 0);
    load_const(8, 8'h55, 8'h40); run_job(0, 2, 5);

    // Abort a job mid-feed with reset, then rerun it cleanly
    load_const(8, 8'h55, 8'h40);
    send_cmd(8, c0);
    fed = 0;
    feed(0, 3);
    in_valid = 1'b1; in_weights = 8'h55; in_act = 8'h40;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd0);
    check_eq("abort_lane_zero", 32'(arr_left_zero), 32'hF);
    check_eq("abort_strobes", 32'({arr_restart_inputs, arr_reset_accumulators,
                                   arr_copy_to_out_queue, arr_restart_out_queue}), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    load_const(8, 8'h55, 8'h40); run_job(0, -1, 0);

    for (int j = 0; j < 8; j++) begin
      load_rand($urandom_range(0, 24));
      run_job(2, -2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
